proc_datapath: RTL and testbench
================================

PROC_DATAPATH -- requirements
Module: proc_datapath

Interface
REQ-001 SHALL have parameter W, default 10, bus/register width in bits.
REQ-002 SHALL have parameter NREG, default 8, number of general registers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port run  input  1  start request; leaves T=0 when high.
REQ-006 SHALL have port DIN  input  W  external data, driven onto the bus by Ext.
REQ-007 SHALL have ports Rin, Rout  input  3 each  write-select and read-select register index.
REQ-008 SHALL have ports ENW, ENR, Ain, Gin, Gout, Ext, IRin, done  input  1 each  control strobes from the controller.
REQ-009 SHALL have port ALUcont  input  3  ALU operation code.
REQ-010 SHALL have port INSTR  output  W  instruction register contents.
REQ-011 SHALL have port T  output  2  current timestep.
REQ-012 SHALL have port BUS  output  W  current bus value, combinational.
REQ-013 SHALL have port bus_err  output  1  sticky flag for multiple bus drivers.
REQ-014 SHALL have ports dbg_sel (input 3) and dbg_data (output W): combinational register readback.

Function
REQ-015 BUS priority SHALL be:
- Ext: DIN
- else Gout: G
- else ENR: R[Rout]
- else all zeros.
REQ-016 Two or more of Ext/Gout/ENR high in one cycle SHALL set bus_err the next cycle; bus_err SHALL stay high until rst.
REQ-017 Register write, for all registers with one-cycle latency:
- ENW=1: R[Rin] <= BUS at the edge.
- Other registers SHALL be unchanged.
REQ-018 Ain=1 SHALL load A <= BUS.
REQ-019 IRin=1 SHALL load IR <= BUS; INSTR SHALL show the new value the cycle after the edge.
REQ-020 Gin=1 SHALL load G <= ALU(A, BUS), computed with the pre-edge A.
REQ-021 ALU operations, all results truncated to W bits (mod 2^W, no carry/borrow out):
- 000 A+BUS
- 001 A-BUS
- 010 ~BUS
- 011 A&BUS
- 100 A|BUS
- 101 A^BUS
- 110/111 pass BUS.
REQ-022 Ain and Gin high in the same cycle: G SHALL use old A, and A SHALL take BUS.
REQ-023 Timestep sequencing, in priority order:
- done=1: T SHALL go to 0 next cycle.
- else T=0 and run=0: T SHALL hold.
- else T SHALL advance by 1, wrapping 3->0.
REQ-024 done SHALL override run and wrap in the same cycle.
REQ-025 Strobes SHALL act regardless of T; the datapath SHALL NOT qualify strobes with T.
REQ-026 ENW with Rin equal to Rout and ENR=1 SHALL write back the pre-edge value (read-before-write).
REQ-027 dbg_data SHALL equal R[dbg_sel] combinationally, showing the pre-edge value within a write cycle.

Reset
REQ-028 rst=1 at an edge SHALL clear R[0..NREG-1], A, G, IR, T and bus_err to 0, overriding all strobes.
REQ-029 rst asserted mid-instruction (T=1..3) SHALL return T to 0 and discard any pending write from that cycle.
REQ-030 BUS SHALL remain combinational during rst; after reset with all strobes low, BUS SHALL be 0.

Structure
REQ-031 The shared package SHALL hold:
- W
- NREG
- an enum of ALU op codes 000..101
- the timestep constants T0..T3.
REQ-032 The register file SHALL be one sub-module, proc_regfile: NREG x W, one synchronous write port, two combinational read ports (Rout, dbg_sel).
REQ-033 Bus mux, A, G, IR, ALU and the T counter SHALL live in proc_datapath.

Verification
REQ-034 Load: DIN=0x2A5, Ext=1, ENW=1, Rin=3 -> R3=0x2A5 next cycle (dbg_sel=3); bus_err=0.
REQ-035 Add wrap: R1=0x3FF, R2=0x002. Sequence Rout=1/ENR/Ain, then Rout=2/ENR/Gin/ALUcont=000, then Gout/ENW/Rin=4 -> R4=0x001.
REQ-036 Sub/xor: A=0x005, BUS=0x006, op 001 -> G=0x3FF; A=0x0F0, BUS=0x0FF, op 101 -> G=0x00F.
REQ-037 T sequencing:
- run=0 -> T holds 0.
- run=1 pulse -> T=1,2,3,0.
- done at T=1 -> T=0 next cycle.
REQ-038 Conflict: Ext=1 and Gout=1 together -> BUS=DIN, bus_err=1 next cycle and held until rst.
REQ-039 Reset mid-op: T=2, ENW=1, Rin=5 with rst=1 -> R5=0, T=0, A=G=IR=0 next cycle.

Source files
------------

// File: rtl/proc_datapath_pkg.sv
// Shared widths, ALU op codes and timestep encodings for the processor datapath.
package proc_datapath_pkg;

   localparam int W    = 10;
   localparam int NREG = 8;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_NOT = 3'b010,
      ALU_AND = 3'b011,
      ALU_OR  = 3'b100,
      ALU_XOR = 3'b101
   } alu_op_e;

   localparam logic [1:0] T0 = 2'd0;
   localparam logic [1:0] T1 = 2'd1;
   localparam logic [1:0] T2 = 2'd2;
   localparam logic [1:0] T3 = 2'd3;

endpackage

// File: rtl/proc_regfile.sv
// General register file: NREG x W, one synchronous write port, two combinational read ports.
module proc_regfile #(
   parameter int W    = 10,
   parameter int NREG = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [2:0]   waddr,
   input  logic [W-1:0] wdata,
   input  logic [2:0]   raddr,
   output logic [W-1:0] rdata,
   input  logic [2:0]   dbg_sel,
   output logic [W-1:0] dbg_data
);

   logic [W-1:0] rf_q [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else if (we && (int'(waddr) < NREG)) begin
         rf_q[waddr] <= wdata;
      end
   end

   // Indices beyond NREG read as zero so a smaller file never returns X.
   assign rdata    = (int'(raddr)   < NREG) ? rf_q[raddr]   : '0;
   assign dbg_data = (int'(dbg_sel) < NREG) ? rf_q[dbg_sel] : '0;

endmodule

// File: rtl/proc_datapath.sv
// Processor datapath: shared bus mux, A/G/IR registers, ALU and the timestep sequencer.
// T | meaning: T0 idle, waits for run | T1..T3 instruction steps, T3 wraps to T0 | done forces T0
module proc_datapath #(
   parameter int W    = proc_datapath_pkg::W,
   parameter int NREG = proc_datapath_pkg::NREG
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         run,
   input  logic [W-1:0] DIN,
   input  logic [2:0]   Rin,
   input  logic [2:0]   Rout,
   input  logic         ENW,
   input  logic         ENR,
   input  logic         Ain,
   input  logic         Gin,
   input  logic         Gout,
   input  logic         Ext,
   input  logic         IRin,
   input  logic         done,
   input  logic [2:0]   ALUcont,
   output logic [W-1:0] INSTR,
   output logic [1:0]   T,
   output logic [W-1:0] BUS,
   output logic         bus_err,
   input  logic [2:0]   dbg_sel,
   output logic [W-1:0] dbg_data
);

   import proc_datapath_pkg::*;

   logic [W-1:0] a_q, a_d;
   logic [W-1:0] g_q, g_d;
   logic [W-1:0] ir_q, ir_d;
   logic [1:0]   t_q, t_d;
   logic         bus_err_q, bus_err_d;
   logic [W-1:0] bus;
   logic [W-1:0] rf_rdata;
   logic [W-1:0] alu_res;
   logic [1:0]   n_drivers;

   proc_regfile #(
      .W    (W),
      .NREG (NREG)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we       (ENW),
      .waddr    (Rin),
      .wdata    (bus),
      .raddr    (Rout),
      .rdata    (rf_rdata),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data)
   );

   always_comb begin
      bus = '0;
      if (Ext) begin
         bus = DIN;
      end else if (Gout) begin
         bus = g_q;
      end else if (ENR) begin
         bus = rf_rdata;
      end
   end

   always_comb begin
      alu_res = bus;
      case (ALUcont)
         ALU_ADD: alu_res = a_q + bus;
         ALU_SUB: alu_res = a_q - bus;
         ALU_NOT: alu_res = ~bus;
         ALU_AND: alu_res = a_q & bus;
         ALU_OR:  alu_res = a_q | bus;
         ALU_XOR: alu_res = a_q ^ bus;
         default: alu_res = bus;
      endcase
   end

   assign n_drivers = {1'b0, Ext} + {1'b0, Gout} + {1'b0, ENR};

   always_comb begin
      a_d       = Ain  ? bus     : a_q;
      g_d       = Gin  ? alu_res : g_q;
      ir_d      = IRin ? bus     : ir_q;
      bus_err_d = bus_err_q | (n_drivers >= 2'd2);
      t_d       = T0;
      if (!done) begin
         case (t_q)
            T0:      t_d = run ? T1 : T0;
            T1:      t_d = T2;
            T2:      t_d = T3;
            default: t_d = T0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= '0;
         g_q       <= '0;
         ir_q      <= '0;
         t_q       <= T0;
         bus_err_q <= 1'b0;
      end else begin
         a_q       <= a_d;
         g_q       <= g_d;
         ir_q      <= ir_d;
         t_q       <= t_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign BUS     = bus;
   assign INSTR   = ir_q;
   assign T       = t_q;
   assign bus_err = bus_err_q;

endmodule

// File: tb/tb_proc_datapath.sv
// Directed bench for proc_datapath: per-cycle compare against a behavioural model plus literal spot checks.
module tb_proc_datapath;

   localparam int W   = 10;
   localparam int MSK = 'h3FF;

   logic         clk = 1'b0;
   logic         rst, run, ENW, ENR, Ain, Gin, Gout, Ext, IRin, done;
   logic [W-1:0] DIN;
   logic [2:0]   Rin, Rout, ALUcont, dbg_sel;
   logic [W-1:0] INSTR, BUS, dbg_data;
   logic [1:0]   T;
   logic         bus_err;

   int checks = 0;
   int errors = 0;

   int m_r [8];
   int m_a, m_g, m_ir, m_t;
   bit m_err;
   bit m_valid = 1'b0;

   always #5 clk = ~clk;

   proc_datapath #(.W(W), .NREG(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .DIN      (DIN),
      .Rin      (Rin),
      .Rout     (Rout),
      .ENW      (ENW),
      .ENR      (ENR),
      .Ain      (Ain),
      .Gin      (Gin),
      .Gout     (Gout),
      .Ext      (Ext),
      .IRin     (IRin),
      .done     (done),
      .ALUcont  (ALUcont),
      .INSTR    (INSTR),
      .T        (T),
      .BUS      (BUS),
      .bus_err  (bus_err),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_bus();
      if (Ext)       return int'(DIN);
      else if (Gout) return m_g;
      else if (ENR)  return m_r[Rout];
      else           return 0;
   endfunction

   function automatic int m_alu(input int op, input int a, input int b);
      case (op)
         0:       return (a + b) & MSK;
         1:       return (a - b) & MSK;
         2:       return (~b) & MSK;
         3:       return a & b;
         4:       return a | b;
         5:       return a ^ b;
         default: return b;
      endcase
   endfunction

   always @(posedge clk) begin
      int b;
      int old_a;
      b = m_bus();
      if (rst) begin
         foreach (m_r[i]) m_r[i] = 0;
         m_a = 0; m_g = 0; m_ir = 0; m_t = 0; m_err = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         old_a = m_a;
         if (ENW)  m_r[Rin] = b;
         if (Ain)  m_a = b;
         if (Gin)  m_g = m_alu(int'(ALUcont), old_a, b);
         if (IRin) m_ir = b;
         if ((int'(Ext) + int'(Gout) + int'(ENR)) >= 2) m_err = 1'b1;
         if (done)                   m_t = 0;
         else if (m_t == 0 && !run)  m_t = 0;
         else                        m_t = (m_t + 1) % 4;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("bus",      int'(BUS),      m_bus());
         chk("dbg_data", int'(dbg_data), m_r[dbg_sel]);
         chk("instr",    int'(INSTR),    m_ir);
         chk("t",        int'(T),        m_t);
         chk("bus_err",  int'(bus_err),  int'(m_err));
      end
   end

   task automatic idle();
      rst = 0; run = 0; done = 0;
      ENW = 0; ENR = 0; Ain = 0; Gin = 0; Gout = 0; Ext = 0; IRin = 0;
      DIN = '0; Rin = '0; Rout = '0; ALUcont = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ext_load(input int v, input int r);
      idle(); Ext = 1; DIN = W'(v); ENW = 1; Rin = 3'(r);
      tick();
   endtask

   int exp_ops [8];

   initial begin
      exp_ops = '{0, 0, 'h35A, 'h081, 'h0E7, 'h066, 'h0A5, 'h0A5};
      idle(); dbg_sel = 3'd0; rst = 1;
      tick();
      idle(); #1;
      chk("rst_t", int'(T), 0);
      chk("rst_bus", int'(BUS), 0);
      chk("rst_err", int'(bus_err), 0);
      chk("rst_instr", int'(INSTR), 0);

      idle(); Ext = 1; DIN = 'h2A5; ENW = 1; Rin = 3; dbg_sel = 3;
      tick();
      idle(); #1;
      chk("load_r3", int'(dbg_data), 'h2A5);
      chk("load_err", int'(bus_err), 0);

      ext_load('h3FF, 1);
      ext_load('h002, 2);
      idle(); Rout = 1; ENR = 1; Ain = 1; tick();
      idle(); Rout = 2; ENR = 1; Gin = 1; ALUcont = 3'b000; tick();
      idle(); Gout = 1; ENW = 1; Rin = 4; dbg_sel = 4; tick();
      idle(); #1;
      chk("add_wrap_r4", int'(dbg_data), 'h001);

      idle(); Ext = 1; DIN = 'h005; Ain = 1; tick();
      idle(); Ext = 1; DIN = 'h006; Gin = 1; ALUcont = 3'b001; tick();
      idle(); Gout = 1; #1;
      chk("sub_g", int'(BUS), 'h3FF);
      tick();
      idle(); Ext = 1; DIN = 'h0F0; Ain = 1; tick();
      idle(); Ext = 1; DIN = 'h0FF; Gin = 1; ALUcont = 3'b101; tick();
      idle(); Gout = 1; #1;
      chk("xor_g", int'(BUS), 'h00F);
      tick();

      // A was 0x0F0: G must use it while A takes the new bus value
      idle(); Ext = 1; DIN = 'h010; Ain = 1; Gin = 1; ALUcont = 3'b000; tick();
      idle(); Gout = 1; #1;
      chk("ain_gin_g", int'(BUS), 'h100);
      tick();
      idle(); Ext = 1; DIN = '0; Gin = 1; ALUcont = 3'b000; tick();
      idle(); Gout = 1; #1;
      chk("ain_gin_a", int'(BUS), 'h010);
      tick();

      for (int op = 2; op < 8; op++) begin
         idle(); Ext = 1; DIN = 'h0C3; Ain = 1; tick();
         idle(); Ext = 1; DIN = 'h0A5; Gin = 1; ALUcont = 3'(op); tick();
         idle(); Gout = 1; #1;
         chk($sformatf("alu_op%0d", op), int'(BUS), exp_ops[op]);
         tick();
      end

      idle(); Ext = 1; DIN = 'h155; IRin = 1; tick();
      idle(); #1;
      chk("ir_load", int'(INSTR), 'h155);

      idle(); ENR = 1; Rout = 1; ENW = 1; Rin = 1; dbg_sel = 1; tick();
      idle(); #1;
      chk("rbw_r1", int'(dbg_data), 'h3FF);

      idle(); repeat (3) tick();
      chk("t_hold", int'(T), 0);
      run = 1; tick();
      idle(); #1; chk("t_seq1", int'(T), 1);
      tick(); chk("t_seq2", int'(T), 2);
      tick(); chk("t_seq3", int'(T), 3);
      tick(); chk("t_seq0", int'(T), 0);
      tick(); chk("t_seq_hold", int'(T), 0);
      run = 1; tick();
      idle(); done = 1; #1;
      chk("t_done_pre", int'(T), 1);
      tick();
      idle(); #1;
      chk("t_done", int'(T), 0);
      run = 1; done = 1; tick();
      idle(); #1;
      chk("t_done_run", int'(T), 0);

      idle(); Ext = 1; Gout = 1; DIN = 'h123; #1;
      chk("conflict_bus", int'(BUS), 'h123);
      chk("conflict_err_pre", int'(bus_err), 0);
      tick();
      idle(); #1;
      chk("conflict_err", int'(bus_err), 1);
      repeat (3) tick();
      chk("conflict_sticky", int'(bus_err), 1);

      ext_load('h1EE, 5);
      idle(); Ext = 1; DIN = 'h0AA; Ain = 1; IRin = 1; Gin = 1; ALUcont = 3'b110; tick();
      idle(); run = 1; tick();
      idle(); tick();
      idle(); rst = 1; Ext = 1; DIN = 'h077; ENW = 1; Rin = 5; dbg_sel = 5; #1;
      chk("midop_t_pre", int'(T), 2);
      chk("midop_r5_pre", int'(dbg_data), 'h1EE);
      tick();
      idle(); #1;
      chk("midop_r5", int'(dbg_data), 0);
      chk("midop_t", int'(T), 0);
      chk("midop_ir", int'(INSTR), 0);
      chk("midop_err", int'(bus_err), 0);
      chk("midop_bus_idle", int'(BUS), 0);
      Gout = 1; #1;
      chk("midop_g", int'(BUS), 0);
      tick();
      idle(); Gin = 1; ALUcont = 3'b000; tick();
      idle(); Gout = 1; #1;
      chk("midop_a", int'(BUS), 0);
      tick();
      idle(); repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
